// File: rtl/leading_zero_stripper_pkg.sv
// rtl/leading_zero_stripper_pkg.sv - shared widths, state encoding and legal CHUNK values
package leading_zero_stripper_pkg;

   localparam int WORD_W  = 32;
   localparam int COUNT_W = 6;
   localparam int LZ_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int CHUNK_LEGAL_0 = 1;
   localparam int CHUNK_LEGAL_1 = 2;
   localparam int CHUNK_LEGAL_2 = 4;
   localparam int CHUNK_LEGAL_3 = 8;

   function automatic logic chunk_legal(input int c);
      return (c == CHUNK_LEGAL_0) || (c == CHUNK_LEGAL_1) ||
             (c == CHUNK_LEGAL_2) || (c == CHUNK_LEGAL_3);
   endfunction

endpackage

// File: rtl/lz_chunk_encoder.sv
// rtl/lz_chunk_encoder.sv - combinational CHUNK-bit leading-zero priority encoder
module lz_chunk_encoder
   import leading_zero_stripper_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] chunk,
   output logic             all_zero,
   output logic [LZ_W-1:0]  lz
);

   assign all_zero = ~|chunk;

   // Scan upward so the highest set bit is the last (winning) assignment.
   always_comb begin
      lz = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk[i]) begin
            lz = LZ_W'(CHUNK - 1 - i);
         end
      end
   end

endmodule

// File: rtl/leading_zero_stripper.sv
// rtl/leading_zero_stripper.sv - iterative leading-zero count and normalise; option LZS_ZERO_BYPASS_EN
module leading_zero_stripper
   import leading_zero_stripper_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WORD_W-1:0]   in_word,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  lz_count,
   output logic [WORD_W-1:0]   norm_word,
   output logic                is_zero
);

   state_e               state_q, state_d;
   logic [WORD_W-1:0]    work_q, work_d;
   logic [COUNT_W-1:0]   count_q, count_d;

   logic [CHUNK-1:0]     top_chunk;
   logic                 chunk_all_zero;
   logic [LZ_W-1:0]      chunk_lz;

   assign top_chunk = work_q[WORD_W-1 -: CHUNK];

   lz_chunk_encoder #(
      .CHUNK (CHUNK)
   ) u_enc (
      .chunk    (top_chunk),
      .all_zero (chunk_all_zero),
      .lz       (chunk_lz)
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d  = in_word;
               count_d = '0;
               state_d = ST_SCAN;
`ifdef LZS_ZERO_BYPASS_EN
               if (in_word == '0) begin
                  count_d = COUNT_W'(WORD_W);
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_SCAN: begin
            if (chunk_all_zero) begin
               work_d  = work_q << CHUNK;
               count_d = count_q + COUNT_W'(CHUNK);
               if (count_d == COUNT_W'(WORD_W)) begin
                  state_d = ST_DONE;
               end
            end else begin
               work_d  = work_q << chunk_lz;
               count_d = count_q + COUNT_W'(chunk_lz);
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         count_q <= count_d;
      end
   end

   // Only an all-zero operand can push the count to a full word.
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign lz_count  = count_q;
   assign norm_word = work_q;
   assign is_zero   = (count_q == COUNT_W'(WORD_W));

endmodule
